// File: rtl/bus_xfer_sequencer.sv
// rtl/bus_xfer_sequencer.sv - queued data/address-bus transfer sequencer with timed strobes
module bus_xfer_sequencer #(
  parameter int ID_W       = 5,
  parameter int N_DEV      = 19,
  parameter int AID_W      = 2,
  parameter int N_AMST     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_W     = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ID_W-1:0]   i_cmd_mid,
  input  logic [ID_W-1:0]   i_cmd_sid,
  input  logic [AID_W-1:0]  i_cmd_amid,
  input  logic [WAIT_W-1:0] i_cmd_wait,
  input  logic              i_cmd_pc_inr,
  input  logic              i_hlt,
  output logic [N_DEV-1:0]  o_oe,
  output logic [N_DEV-1:0]  o_we,
  output logic [N_AMST-1:0] o_oe_addr,
  output logic              o_pc_inr,
  output logic              o_xfer_done,
  output logic              o_busy,
  output logic              o_err_illegal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ID_W:0]       LP_N_DEV    = (ID_W+1)'(N_DEV);
  localparam logic [AID_W:0]      LP_N_AMST   = (AID_W+1)'(N_AMST);
  localparam logic [CNT_W-1:0]    LP_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [N_DEV-1:0]    LP_DEV_ONE  = N_DEV'(1);
  localparam logic [N_AMST-1:0]   LP_AMST_ONE = N_AMST'(1);
  localparam logic [WAIT_W-1:0]   LP_WAIT_ONE = WAIT_W'(1);
  localparam logic [PTR_W-1:0]    LP_PTR_ONE  = PTR_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_STROBE = 2'd3;

  typedef struct packed {
    logic              pc_inr;
    logic [WAIT_W-1:0] wt;
    logic [AID_W-1:0]  amid;
    logic [ID_W-1:0]   sid;
    logic [ID_W-1:0]   mid;
  } cmd_t;

  // Command queue storage and bookkeeping
  cmd_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Sequencer state and the transfer currently on the bus
  logic [1:0]        r_state;
  cmd_t              r_cur;
  logic [WAIT_W-1:0] r_wcnt;

  // Registered outputs
  logic              r_cmd_ready;
  logic [N_DEV-1:0]  r_oe;
  logic [N_DEV-1:0]  r_we;
  logic [N_AMST-1:0] r_oe_addr;
  logic              r_pc_inr;
  logic              r_xfer_done;
  logic              r_busy;
  logic              r_err_illegal;

  logic              w_illegal;
  logic              w_take;
  logic              w_push;
  logic              w_can_pop;
  logic              w_pop;
  logic [1:0]        w_state_nxt;
  logic [WAIT_W-1:0] w_wcnt_nxt;
  cmd_t              w_cmd_nxt;
  cmd_t              w_cmd_in;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [N_DEV-1:0]  w_oe_nxt;
  logic [N_DEV-1:0]  w_we_nxt;
  logic [N_AMST-1:0] w_oe_addr_nxt;
  logic              w_pc_nxt;
  logic              w_done_nxt;
  logic              w_busy_nxt;

  // A rejected command is still consumed so the producer never stalls on it
  assign w_illegal = ({1'b0, i_cmd_mid} >= LP_N_DEV) |
                     ({1'b0, i_cmd_sid} >= LP_N_DEV) |
                     (i_cmd_mid == i_cmd_sid) |
                     ({1'b0, i_cmd_amid} >= LP_N_AMST);
  assign w_take    = i_cmd_valid & r_cmd_ready;
  assign w_push    = w_take & ~w_illegal;
  assign w_can_pop = (r_count != '0) & ~i_hlt;

  assign w_cmd_in.pc_inr = i_cmd_pc_inr;
  assign w_cmd_in.wt     = i_cmd_wait;
  assign w_cmd_in.amid   = i_cmd_amid;
  assign w_cmd_in.sid    = i_cmd_sid;
  assign w_cmd_in.mid    = i_cmd_mid;

  // Next-state logic; a pop only happens from IDLE or STROBE so halts never abort a transfer
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pop       = 1'b0;
    w_cmd_nxt   = r_cur;
    case (r_state)
      ST_IDLE: begin
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cur.wt == '0) begin
          w_state_nxt = ST_STROBE;
        end else begin
          w_state_nxt = ST_WAIT;
          w_wcnt_nxt  = r_cur.wt;
        end
      end
      ST_WAIT: begin
        if (r_wcnt == LP_WAIT_ONE) begin
          w_state_nxt = ST_STROBE;
        end else begin
          w_wcnt_nxt = r_wcnt - LP_WAIT_ONE;
        end
      end
      ST_STROBE: begin
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_pop) begin
      w_cmd_nxt = r_mem[r_rd_ptr];
    end
  end

  // Outputs are decoded from the next state so they appear registered in the phase they belong to
  always_comb begin
    w_oe_nxt      = '0;
    w_we_nxt      = '0;
    w_oe_addr_nxt = LP_AMST_ONE;
    w_pc_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    if (w_state_nxt != ST_IDLE) begin
      w_oe_nxt      = LP_DEV_ONE << w_cmd_nxt.mid;
      w_oe_addr_nxt = LP_AMST_ONE << w_cmd_nxt.amid;
    end
    if (w_state_nxt == ST_STROBE) begin
      w_we_nxt   = LP_DEV_ONE << w_cmd_nxt.sid;
      w_pc_nxt   = w_cmd_nxt.pc_inr;
      w_done_nxt = 1'b1;
    end
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_busy_nxt  = (w_state_nxt != ST_IDLE) | (w_count_nxt != '0);

  // Queue payload write; contents are meaningless until the count covers them
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_cmd_in;
    end
  end

  // Queue pointers, count, sequencer state and current command
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_IDLE;
      r_cur    <= '0;
      r_wcnt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      r_cur   <= w_cmd_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Output registers; reset drops every strobe and reselects the PC as address master
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cmd_ready   <= 1'b1;
      r_oe          <= '0;
      r_we          <= '0;
      r_oe_addr     <= LP_AMST_ONE;
      r_pc_inr      <= 1'b0;
      r_xfer_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_cmd_ready   <= (w_count_nxt != LP_DEPTH);
      r_oe          <= w_oe_nxt;
      r_we          <= w_we_nxt;
      r_oe_addr     <= w_oe_addr_nxt;
      r_pc_inr      <= w_pc_nxt;
      r_xfer_done   <= w_done_nxt;
      r_busy        <= w_busy_nxt;
      r_err_illegal <= w_take & w_illegal;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_oe          = r_oe;
  assign o_we          = r_we;
  assign o_oe_addr     = r_oe_addr;
  assign o_pc_inr      = r_pc_inr;
  assign o_xfer_done   = r_xfer_done;
  assign o_busy        = r_busy;
  assign o_err_illegal = r_err_illegal;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb/tb_bus_xfer_sequencer.sv - self-checking bench for bus_xfer_sequencer
module tb_bus_xfer_sequencer;
  localparam int ID_W = 5, N_DEV = 19, AID_W = 2, N_AMST = 4, FIFO_DEPTH = 4, WAIT_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ID_W-1:0]   cmd_mid;
  logic [ID_W-1:0]   cmd_sid;
  logic [AID_W-1:0]  cmd_amid;
  logic [WAIT_W-1:0] cmd_wait;
  logic              cmd_pc_inr;
  logic              hlt;
  logic [N_DEV-1:0]  oe;
  logic [N_DEV-1:0]  we;
  logic [N_AMST-1:0] oe_addr;
  logic              pc_inr;
  logic              xfer_done;
  logic              busy;
  logic              err_illegal;

  int checks = 0;
  int errors = 0;

  bus_xfer_sequencer #(
    .ID_W(ID_W), .N_DEV(N_DEV), .AID_W(AID_W), .N_AMST(N_AMST),
    .FIFO_DEPTH(FIFO_DEPTH), .WAIT_W(WAIT_W)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_mid(cmd_mid), .i_cmd_sid(cmd_sid), .i_cmd_amid(cmd_amid),
    .i_cmd_wait(cmd_wait), .i_cmd_pc_inr(cmd_pc_inr), .i_hlt(hlt),
    .o_oe(oe), .o_we(we), .o_oe_addr(oe_addr), .o_pc_inr(pc_inr),
    .o_xfer_done(xfer_done), .o_busy(busy), .o_err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of commands plus the active transfer and its cycle index
  // (0 = settle, 1..wt = wait cycles, wt+1 = strobe).
  typedef struct { int mid; int sid; int amid; int wt; bit pc; } mcmd_t;
  mcmd_t m_q[$];
  mcmd_t m_cur;
  bit    m_act;
  int    m_k;
  bit    m_err;

  task automatic model_reset();
    m_q.delete();
    m_act = 1'b0;
    m_k   = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit take, legal, start;
    mcmd_t c;
    take  = cmd_valid && (m_q.size() < FIFO_DEPTH);
    legal = (cmd_mid < N_DEV) && (cmd_sid < N_DEV) && (cmd_mid != cmd_sid) && (cmd_amid < N_AMST);
    start = (!m_act || m_k == m_cur.wt + 1) && (m_q.size() > 0) && !hlt;
    if (m_act) begin
      if (m_k == m_cur.wt + 1) m_act = 1'b0;
      else m_k++;
    end
    if (start) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_k   = 0;
    end
    if (take && legal) begin
      c.mid = int'(cmd_mid); c.sid = int'(cmd_sid); c.amid = int'(cmd_amid);
      c.wt = int'(cmd_wait); c.pc = cmd_pc_inr;
      m_q.push_back(c);
    end
    m_err = take && !legal;
  endtask

  function automatic logic [46:0] pk(logic [18:0] e_oe, logic [18:0] e_we, logic [3:0] e_oea,
                                     logic e_pc, logic e_dn, logic e_bz, logic e_rd, logic e_er);
    return {e_oe, e_we, e_oea, e_pc, e_dn, e_bz, e_rd, e_er};
  endfunction

  function automatic logic [46:0] exp_vec();
    logic [18:0] e_oe = '0;
    logic [18:0] e_we = '0;
    logic [3:0]  e_oea = 4'b0001;
    logic        e_pc = 1'b0;
    logic        e_dn = 1'b0;
    if (m_act) begin
      e_oe[m_cur.mid] = 1'b1;
      e_oea = '0;
      e_oea[m_cur.amid] = 1'b1;
      if (m_k == m_cur.wt + 1) begin
        e_we[m_cur.sid] = 1'b1;
        e_pc = m_cur.pc;
        e_dn = 1'b1;
      end
    end
    return pk(e_oe, e_we, e_oea, e_pc, e_dn, (m_act || m_q.size() > 0),
              (m_q.size() < FIFO_DEPTH), m_err);
  endfunction

  function automatic logic [46:0] dut_vec();
    return {oe, we, oe_addr, pc_inr, xfer_done, busy, cmd_ready, err_illegal};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cycle(string nm);
    @(posedge clk);
    model_edge();
    #1;
    chk(nm, 64'(dut_vec()), 64'(exp_vec()));
  endtask

  task automatic set_cmd(logic v, int mid, int sid, int amid, int wt, logic pc);
    cmd_valid  = v;
    cmd_mid    = ID_W'(mid);
    cmd_sid    = ID_W'(sid);
    cmd_amid   = AID_W'(amid);
    cmd_wait   = WAIT_W'(wt);
    cmd_pc_inr = pc;
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 60 && (m_act || m_q.size() > 0); i++) cycle(nm);
    chk({nm, "_idle"}, 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic        v;
    int          mid;
    int          sid;
    int          amid;
    int          wt;
    logic        pc;
    logic [46:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   done_t[$];
  int   nw;
  bit   seen;

  initial begin
    reset = 1'b1;
    hlt   = 1'b0;
    set_cmd(1'b0, 0, 1, 0, 0, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", 64'(dut_vec()), 64'(pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 0)));
    @(negedge clk);
    reset = 1'b0;

    // Single transfer then illegal rejections
    vecs[0] = '{1'b1, 2, 4, 1, 0, 1'b1, pk(19'h0, 19'h0, 4'b0001, 0, 0, 1, 1, 0)};
    vecs[1] = '{1'b0, 0, 1, 0, 0, 1'b0, pk(19'h4, 19'h0, 4'b0010, 0, 0, 1, 1, 0)};
    vecs[2] = '{1'b0, 0, 1, 0, 0, 1'b0, pk(19'h4, 19'h10, 4'b0010, 1, 1, 1, 1, 0)};
    vecs[3] = '{1'b0, 0, 1, 0, 0, 1'b0, pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 0)};
    vecs[4] = '{1'b1, 3, 3, 0, 0, 1'b0, pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 1)};
    vecs[5] = '{1'b1, 1, 25, 0, 0, 1'b0, pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 1)};
    vecs[6] = '{1'b1, 19, 0, 2, 1, 1'b1, pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 1)};
    vecs[7] = '{1'b0, 0, 1, 0, 0, 1'b0, pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 0)};
    for (int i = 0; i < 8; i++) begin
      set_cmd(vecs[i].v, vecs[i].mid, vecs[i].sid, vecs[i].amid, vecs[i].wt, vecs[i].pc);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("vec%0d", i), 64'(dut_vec()), 64'(vecs[i].exp));
    end

    // Wait states: settle + 3 wait cycles with we low, then strobe
    set_cmd(1'b1, 5, 6, 2, 3, 1'b0);
    cycle("wait_push");
    set_cmd(1'b0, 0, 1, 0, 0, 1'b0);
    nw = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle("wait_seq");
      if (oe != '0 && we == '0) nw++;
      if (xfer_done) seen = 1'b1;
    end
    chk("wait_strobe_seen", 64'(seen), 64'(1));
    chk("wait_cycles", 64'(nw), 64'(4));
    drain("wait_drain");

    // Fill the queue under halt, then release for back-to-back transfers
    hlt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b1, i, i + 1, i % 4, 0, 1'(i & 1));
      cycle("fill");
      if (i == 3) chk("fill_ready_low", 64'(cmd_ready), 64'(0));
    end
    set_cmd(1'b0, 0, 1, 0, 0, 1'b0);
    hlt = 1'b0;
    done_t.delete();
    for (int i = 0; i < 30; i++) begin
      cycle("b2b");
      if (xfer_done) done_t.push_back(i);
    end
    chk("b2b_count", 64'(done_t.size()), 64'(4));
    for (int i = 1; i < done_t.size(); i++) chk("b2b_gap", 64'(done_t[i] - done_t[i-1]), 64'(2));
    drain("b2b_drain");

    // Halt raised during WAIT with two commands queued behind
    set_cmd(1'b1, 1, 2, 0, 2, 1'b0);
    cycle("halt_pushA");
    set_cmd(1'b1, 3, 4, 1, 2, 1'b1);
    cycle("halt_pushB");
    set_cmd(1'b1, 5, 6, 3, 0, 1'b0);
    cycle("halt_pushC");
    set_cmd(1'b0, 0, 1, 0, 0, 1'b0);
    chk("halt_in_wait", 64'({oe == 19'h2, we == 19'h0}), 64'(2'b11));
    hlt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle("halt_finish");
      if (xfer_done) seen = 1'b1;
    end
    chk("halt_strobe_done", 64'(seen), 64'(1));
    for (int i = 0; i < 4; i++) begin
      cycle("halt_hold");
      chk("halt_idle_busy", 64'({oe, busy}), 64'({19'h0, 1'b1}));
    end
    hlt = 1'b0;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("halt_resume");
      if (xfer_done) nw++;
    end
    chk("halt_resume_count", 64'(nw), 64'(2));
    drain("halt_drain");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 20),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      hlt = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end
    set_cmd(1'b0, 0, 1, 0, 0, 1'b0);
    hlt = 1'b0;
    drain("rand_drain");

    // Asynchronous reset in the middle of a strobe with commands still queued
    set_cmd(1'b1, 7, 8, 3, 1, 1'b1);
    cycle("rst_pushD");
    set_cmd(1'b1, 9, 10, 2, 0, 1'b1);
    cycle("rst_pushE");
    set_cmd(1'b1, 11, 12, 1, 0, 1'b0);
    cycle("rst_pushF");
    set_cmd(1'b0, 0, 1, 0, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle("rst_run");
      if (xfer_done) seen = 1'b1;
    end
    chk("rst_strobe_seen", 64'({seen, we != '0}), 64'(2'b11));
    reset = 1'b1;
    #1;
    chk("rst_async", 64'(dut_vec()), 64'(pk(19'h0, 19'h0, 4'b0001, 0, 0, 0, 1, 0)));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle("rst_after");
    chk("rst_queue_lost", 64'({busy, oe_addr}), 64'({1'b0, 4'b0001}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
